// File: rtl/watch_pkg.sv
// Shared definitions for the watch blocks: BCD digit limits, the button
// repeat FSM encoding and a helper that splits a binary value into BCD digits.
package watch_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] UNITS_MAX         = 4'd9;
   localparam logic [DIGIT_W-1:0] MIN_TENS_MAX      = 4'd5;
   localparam logic [DIGIT_W-1:0] HOUR_TENS_MAX     = 4'd2;
   localparam logic [DIGIT_W-1:0] HOUR_23_UNITS_MAX = 4'd3;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } repStateT;

   // Returns {tens, units} for a value in 0..99.
   function automatic logic [2*DIGIT_W-1:0] toBcd(input int value);
      toBcd = {4'(value / 10), 4'(value % 10)};
   endfunction

endpackage

// File: rtl/button_repeater.sv
// One push button: 2-flop synchroniser, rising-edge detect and a hold/repeat
// FSM that turns a held button into a stream of one-cycle inc pulses.
module button_repeater
   import watch_pkg::*;
#(
   parameter int HOLD_CYCLES   = 500,
   parameter int REPEAT_CYCLES = 100
) (
   input  logic uclock,
   input  logic reset,
   input  logic btn,
   input  logic enable,
   output logic inc
);

   localparam int CW = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          prevBtn;
   logic          primed;
   logic          armed;
   logic          rise;
   repStateT      state;
   repStateT      stateNext;
   logic [CW-1:0] count;
   logic [CW-1:0] countNext;

   // A button held through reset is only armed once it has been seen low
   // on a post-reset sample, so it needs a fresh press.
   assign rise = sync2 & ~prevBtn & enable & armed;

   always_ff @(posedge uclock or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         prevBtn <= 1'b0;
         primed  <= 1'b0;
         armed   <= 1'b0;
         state   <= IDLE;
         count   <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         prevBtn <= sync2;
         primed  <= 1'b1;
         armed   <= armed | (primed & ~sync1);
         state   <= stateNext;
         count   <= countNext;
      end
   end

   always_comb begin
      stateNext = state;
      countNext = count;
      inc       = 1'b0;
      case (state)
         IDLE: begin
            countNext = '0;
            if (rise) begin
               inc       = 1'b1;
               stateNext = HOLD;
            end
         end
         HOLD: begin
            if (!sync2 || !enable) begin
               stateNext = IDLE;
               countNext = '0;
            end else if (count == CW'(HOLD_CYCLES - 1)) begin
               inc       = 1'b1;
               stateNext = REPEAT;
               countNext = '0;
            end else begin
               countNext = count + 1'b1;
            end
         end
         REPEAT: begin
            if (!sync2 || !enable) begin
               stateNext = IDLE;
               countNext = '0;
            end else if (count == CW'(REPEAT_CYCLES - 1)) begin
               inc       = 1'b1;
               countNext = '0;
            end else begin
               countNext = count + 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
            countNext = '0;
         end
      endcase
   end

endmodule

// File: rtl/alarm_setter.sv
// Alarm time register (HH:MM as four BCD digits) edited by hour and minute
// buttons while set mode is on; hours and minutes wrap independently.
module alarm_setter
   import watch_pkg::*;
#(
   parameter int RESET_HOUR    = 6,
   parameter int RESET_MIN     = 0,
   parameter int HOLD_CYCLES   = 500,
   parameter int REPEAT_CYCLES = 100
) (
   input  logic               uclock,
   input  logic               reset,
   input  logic               setMode,
   input  logic               hourBtn,
   input  logic               minBtn,
   output logic [DIGIT_W-1:0] a0,
   output logic [DIGIT_W-1:0] a1,
   output logic [DIGIT_W-1:0] a2,
   output logic [DIGIT_W-1:0] a3,
   output logic               setting
);

   localparam logic [2*DIGIT_W-1:0] RESET_H_BCD = toBcd(RESET_HOUR);
   localparam logic [2*DIGIT_W-1:0] RESET_M_BCD = toBcd(RESET_MIN);

   logic               modeSync1;
   logic               modeSync2;
   logic               hourInc;
   logic               minInc;
   logic [DIGIT_W-1:0] a0Next;
   logic [DIGIT_W-1:0] a1Next;
   logic [DIGIT_W-1:0] a2Next;
   logic [DIGIT_W-1:0] a3Next;

   button_repeater #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
   ) uHourBtn (
      .uclock(uclock),
      .reset (reset),
      .btn   (hourBtn),
      .enable(modeSync2),
      .inc   (hourInc)
   );

   button_repeater #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
   ) uMinBtn (
      .uclock(uclock),
      .reset (reset),
      .btn   (minBtn),
      .enable(modeSync2),
      .inc   (minInc)
   );

   // Minute and hour fields are updated independently so simultaneous
   // pulses both land in the same cycle.
   always_comb begin
      a0Next = a0;
      a1Next = a1;
      a2Next = a2;
      a3Next = a3;
      if (minInc) begin
         if (a0 == UNITS_MAX) begin
            a0Next = '0;
            a1Next = (a1 == MIN_TENS_MAX) ? '0 : a1 + 4'd1;
         end else begin
            a0Next = a0 + 4'd1;
         end
      end
      if (hourInc) begin
         if (a3 == HOUR_TENS_MAX && a2 == HOUR_23_UNITS_MAX) begin
            a2Next = '0;
            a3Next = '0;
         end else if (a2 == UNITS_MAX) begin
            a2Next = '0;
            a3Next = a3 + 4'd1;
         end else begin
            a2Next = a2 + 4'd1;
         end
      end
   end

   always_ff @(posedge uclock or posedge reset) begin
      if (reset) begin
         modeSync1 <= 1'b0;
         modeSync2 <= 1'b0;
         setting   <= 1'b0;
         a3        <= RESET_H_BCD[2*DIGIT_W-1:DIGIT_W];
         a2        <= RESET_H_BCD[DIGIT_W-1:0];
         a1        <= RESET_M_BCD[2*DIGIT_W-1:DIGIT_W];
         a0        <= RESET_M_BCD[DIGIT_W-1:0];
      end else begin
         modeSync1 <= setMode;
         modeSync2 <= modeSync1;
         setting   <= modeSync2;
         a3        <= a3Next;
         a2        <= a2Next;
         a1        <= a1Next;
         a0        <= a0Next;
      end
   end

endmodule

// File: doc/alarm_setter.md
Name: alarm_setter

Overview:
- Holds the user-programmed alarm time as four BCD digits a3 a2 : a1 a0 (24-hour HH:MM).
- These digits feed the alarm comparator, which matches them against time digits t3..t0.
- The user edits the digits with an hour button and a minute button, only while set mode is enabled.
- Buttons are synchronised, edge-detected and auto-repeated when held.

Parameters:
- RESET_HOUR, 6, hour loaded on reset, 0..23.
- RESET_MIN, 0, minute loaded on reset, 0..59.
- HOLD_CYCLES, 500, uclock cycles from the first pulse to the first auto-repeat pulse, >=2.
- REPEAT_CYCLES, 100, uclock cycles between later auto-repeat pulses, >=2.

Ports:
- uclock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- setMode  in  1  set-mode switch, asynchronous level; 1 = editing enabled.
- hourBtn  in  1  hour increment button, asynchronous, active-high.
- minBtn  in  1  minute increment button, asynchronous, active-high.
- a0  out  4  minutes units, BCD 0..9.
- a1  out  4  minutes tens, BCD 0..5.
- a2  out  4  hours units, BCD 0..9 (0..3 when a3=2).
- a3  out  4  hours tens, BCD 0..2.
- setting  out  1  registered copy of the synchronised setMode; drives the set-mode LED.

Behaviour:
- Reset (asynchronous, active-high):
  - a3..a0 load the BCD form of RESET_HOUR:RESET_MIN, i.e. 06:00 by default.
  - setting = 0.
  - All synchroniser flops, edge flops, repeat counters and FSMs clear.
- Synchronisation:
  - setMode, hourBtn and minBtn each pass through a 2-flop synchroniser.
  - All logic uses only the synchronised versions.
- Increment pulse per button:
  - inc = sync & ~prev & syncMode, or an auto-repeat pulse.
  - A button rising just before edge 1 produces the digit update at edge 3, i.e. 2 cycles of latency after sampling.
- Repeat FSM, one per button:
  - IDLE: on the first pulse -> HOLD, counter cleared.
  - HOLD: counter counts up. When it reaches HOLD_CYCLES-1, emit a pulse, go to REPEAT, clear the counter.
  - REPEAT: emit a pulse every REPEAT_CYCLES cycles.
  - From HOLD or REPEAT, go to IDLE when the synchronised button is 0 or the synchronised setMode is 0. The counter clears and no pulse is emitted that cycle.
- Minute increment:
  - a0 increments.
  - When a0 = 9: a0 -> 0 and a1 increments.
  - 59 -> 00. Never carries into the hours.
- Hour increment:
  - 09 -> 10, 19 -> 20, 23 -> 00.
  - Never touches the minutes.
- Simultaneous hour and minute pulses in one cycle: both apply in that cycle, so 23:59 -> 00:00.
- setMode = 0:
  - Button presses are ignored; digits hold.
  - A button already held when setMode rises generates no pulse. A fresh rising edge is required.
- setMode falling while a button is held: the FSM returns to IDLE on that cycle. Digits keep their last value.
- Output invariant: outputs always form a legal BCD time; no illegal digit combination is ever visible.
- Reset asserted mid-hold: everything returns to its reset values immediately. After reset releases, a still-held button needs a fresh rising edge.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package (watch_pkg):
  - BCD digit width = 4.
  - Limits: MIN_TENS_MAX = 5, HOUR_TENS_MAX = 2, HOUR_23_UNITS_MAX = 3.
  - Repeat FSM state encoding: IDLE, HOLD, REPEAT.
- One sub-module, button_repeater, instantiated twice (hour and minute):
  - Contains the 2-flop synchroniser, edge detect and repeat FSM/counter.
  - Inputs: uclock, reset, btn, enable. Output: a one-cycle inc pulse.
  - Parameters: HOLD_CYCLES, REPEAT_CYCLES.
- alarm_setter contains:
  - the setMode synchroniser;
  - the BCD digit registers and their increment/wrap logic.

Test Plan:
1. Reset sequence: assert reset mid-cycle, release, with setMode = 0 -> a3..a0 = 0,6,0,0 and setting = 0 immediately (asynchronous). Pulse hourBtn -> digits unchanged.
2. Single minute press (setMode = 1, HOLD_CYCLES = 8, REPEAT_CYCLES = 4): minBtn high for 3 cycles -> exactly one increment, 06:00 -> 06:01. Update visible at edge 3 after sampling.
3. Minute wrap and auto-repeat: preload to 06:57, hold minBtn for 20 cycles -> pulses at relative cycles 0, 8, 12, 16, 20. Sequence 06:58, 06:59, 06:00, 06:01, 06:02; the hours never change.
4. Hour boundaries: step hourBtn presses from 06:xx. Check 09 -> 10, 19 -> 20, 23 -> 00. Confirm a1/a0 are untouched and a3 = 2 never occurs with a2 > 3.
5. Simultaneous pulses at 23:59: raise hourBtn and minBtn on the same edge -> 00:00 on a single cycle.
6. Mode and reset interlocks:
   - Hold hourBtn, then raise setMode -> no increment until a release-and-press.
   - Drop setMode mid-REPEAT -> increments stop on that cycle.
   - Assert reset while in REPEAT -> digits back to 06:00 and the FSM in IDLE.
